seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 154 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed driver for a 4-digit, common-anode 7-segment display.
//   It scans one digit per REFRESH_DIV clocks. New values are staged in a
//   pending register and become visible only at a frame boundary, so one
//   scan never shows a mix of old and new digits.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLINK_DIV    clk cycles per blink half-period (>= 2); only used with
//                SEG_BLINK_EN
//
// Ports
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous, active-low reset
//   num[15:0]   in   four BCD digits, [15:12] = digit 0 (leftmost)
//   load        in   capture strobe for num
//   dp[3:0]     in   decimal points, active-high, dp[3] = digit 0
//   sel[3:0]    in   blink select, active-high, sel[3] = digit 0
//   seg[7:0]    out  {dp,g,f,e,d,c,b,a}, active-low, registered
//   anode[3:0]  out  digit enables, active-low, registered, anode[3] = digit 0
//   frame_done  out  one-cycle pulse after the last slot of each scan
//
// Build option
//   SEG_BLINK_EN  when defined, selected digits blank during the odd blink
//                 phase; when undefined, sel and BLINK_DIV have no effect.

module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] num,
  input  logic        load,
  input  logic [3:0]  dp,
  input  logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int unsigned RC_W = $clog2(REFRESH_DIV);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

  logic [RC_W-1:0] rc;
  logic [1:0]      idx;
  logic [15:0]     disp_q;
  logic [15:0]     pend_q;
  logic            pend_flag;

  logic            boundary;
  logic [3:0]      digit;
  logic [6:0]      pattern;
  logic [3:0]      anode_d;
  logic [7:0]      seg_d;

`ifdef SEG_BLINK_EN
  localparam int unsigned BC_W = $clog2(BLINK_DIV);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

  logic [BC_W-1:0] bc;
  logic            blink_phase;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bc          <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (bc == BC_LAST) begin
        bc          <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        bc <= bc + BC_W'(1);
      end
    end
  end
`else
  localparam int unsigned UNUSED_BLINK_DIV = BLINK_DIV;
  logic unused_sel;
  assign unused_sel = ^sel;
`endif

  // Next-cycle outputs are decoded from the current rc/idx/display state.
  always_comb begin
    boundary = (idx == 2'd3) && (rc == RC_LAST);

    case (idx)
      2'd0:    digit = disp_q[15:12];
      2'd1:    digit = disp_q[11:8];
      2'd2:    digit = disp_q[7:4];
      default: digit = disp_q[3:0];
    endcase

    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase

    // The first cycle of every slot keeps all anodes off so the previous
    // digit's segments never flash on the new digit.
    anode_d = '1;
    if (rc != '0) anode_d[2'd3 - idx] = 1'b0;

    seg_d = {~dp[2'd3 - idx], pattern};
`ifdef SEG_BLINK_EN
    if (blink_phase && sel[2'd3 - idx]) seg_d = '1;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rc         <= '0;
      idx        <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_flag  <= 1'b0;
      seg        <= '1;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      anode      <= anode_d;
      frame_done <= boundary;

      if (rc == RC_LAST) begin
        rc  <= '0;
        idx <= idx + 2'd1;
      end else begin
        rc <= rc + RC_W'(1);
      end

      if (load) pend_q <= num;

      // A load landing on the boundary bypasses the pending stage entirely.
      if (boundary) begin
        if (load)           disp_q <= num;
        else if (pend_flag) disp_q <= pend_q;
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
//   Scoreboard bench for seg_scan_driver with REFRESH_DIV=4, BLINK_DIV=32.
//   The stimulus process pushes the hand-computed {anode, seg} expected for
//   each digit slot of each frame; the monitor pops one entry whenever a
//   digit lights and checks every lit cycle, the slot width, and the
//   frame_done pulse count between slots.

module tb_seg_scan_driver;

  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned BLINK_DIV   = 32;

`ifdef SEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] num    = '0;
  logic        load   = 1'b0;
  logic [3:0]  dp     = '0;
  logic [3:0]  sel    = 4'b0010;
  logic [7:0]  seg;
  logic [3:0]  anode;
  logic        frame_done;

  seg_scan_driver #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .num       (num),
    .load      (load),
    .dp        (dp),
    .sel       (sel),
    .seg       (seg),
    .anode     (anode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] seg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Expected seg per frame and digit (blink overrides applied separately).
  logic [7:0] exp_tab [8][4] = '{
    '{8'hC0, 8'hC0, 8'hC0, 8'hC0},   // reset value 0000
    '{8'hC0, 8'hC0, 8'hC0, 8'hC0},   // 1234 pending, not yet shown
    '{8'hF9, 8'hA4, 8'hB0, 8'h99},   // 1234
    '{8'h92, 8'h82, 8'hF8, 8'h80},   // 5678 (loaded mid frame 2)
    '{8'h90, 8'h90, 8'h90, 8'h90},   // 9999 (loaded on boundary)
    '{8'hC0, 8'hF8, 8'hC0, 8'h90},   // 0709 (last of two loads)
    '{8'h7F, 8'hC0, 8'hC0, 8'hC0},   // A000, dp=1000
    '{8'hFF, 8'hC0, 8'hC0, 8'h40}    // A000, dp=0001
  };
  logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [7:0] blink_frames = 8'b1100_1100;  // frames with blink phase 1

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  bit   in_run      = 1'b0;
  bit   first_frame = 1'b1;
  int   run_len     = 0;
  int   fd_cnt      = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      in_run      = 1'b0;
      first_frame = 1'b1;
      run_len     = 0;
      fd_cnt      = 0;
    end else begin
      if (frame_done) fd_cnt++;
      if (anode != 4'hF) begin
        if (!in_run) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: lit anode %b seg %h with no expected entry", anode, seg);
            cur = '0;
          end else begin
            cur = sb_q.pop_front();
          end
          check("frame_done_count", 16'(fd_cnt),
                (cur.anode == 4'b0111 && !first_frame) ? 16'd1 : 16'd0);
          if (cur.anode == 4'b0111) first_frame = 1'b0;
          fd_cnt  = 0;
          in_run  = 1'b1;
          run_len = 0;
        end
        run_len++;
        check("digit_anode_seg", {4'h0, anode, seg}, {4'h0, cur.anode, cur.seg});
      end else if (in_run) begin
        check("slot_width", 16'(run_len), 16'(REFRESH_DIV - 1));
        in_run = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) tick();
  endtask

  // Present num with load so that it is sampled at edge k after release.
  task automatic do_load(input int k, input logic [15:0] v);
    goto(k - 1);
    num  = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [7:0] s);
    exp_t e;
    e.anode = a;
    e.seg   = s;
    sb_q.push_back(e);
  endtask

  task automatic push_frame(input int f);
    logic [7:0] s;
    for (int d = 0; d < 4; d++) begin
      s = exp_tab[f][d];
      if (BLINK_ON && d == 2 && blink_frames[f]) s = 8'hFF;
      push_exp(an_tab[d], s);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_anode", {12'h0, anode}, 16'h000F);
    check("reset_seg",   {8'h0, seg},    16'h00FF);
    check("reset_fd",    {15'h0, frame_done}, 16'h0000);

    resetn = 1'b1;
    cyc    = 0;

    for (int f = 0; f < 8; f++) begin
      goto(16 * f);
      if (f == 6) dp = 4'b1000;
      if (f == 7) dp = 4'b0001;
      push_frame(f);
      case (f)
        1: do_load(17, 16'h1234);
        2: do_load(38, 16'h5678);
        3: do_load(64, 16'h9999);
        4: begin
          do_load(66, 16'h4321);
          do_load(75, 16'h0709);
        end
        5: do_load(85, 16'hA000);
        7: do_load(120, 16'h3000);
        default: ;
      endcase
    end

    // Frame 8: digit 0 shows 3, then reset is asserted mid-slot.
    goto(128);
    dp = 4'b0000;
    push_exp(4'b0111, 8'hB0);
    goto(131);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_anode", {12'h0, anode}, 16'h000F);
    check("async_reset_seg",   {8'h0, seg},    16'h00FF);
    check("async_reset_fd",    {15'h0, frame_done}, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    push_frame(0);
    resetn = 1'b1;
    cyc    = 0;
    tick();
    check("release_ghost_anode", {12'h0, anode}, 16'h000F);
    check("release_ghost_seg",   {8'h0, seg},    16'h00C0);

    goto(17);
    @(negedge clk);
    #1;
    check("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
